// File: rtl/clk_gate_ctrl.sv
// Idle-detect controller driving the enable of a downstream latch-based clock gate.
// Runs on the free-running clock; gates after an idle window, re-enables and settles on wake.
module clk_gate_ctrl #(
  parameter int unsigned IDLE_CYCLES = 16,
  parameter int unsigned WAKE_CYCLES = 2,
  parameter int unsigned CNT_W =
      $clog2(((IDLE_CYCLES > WAKE_CYCLES) ? IDLE_CYCLES : WAKE_CYCLES) + 1)
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_busy,
  input  logic i_wake_req,
  input  logic i_gate_en,
  output logic o_clk_en,
  output logic o_gated,
  output logic o_wake_ack
);

  typedef enum logic [1:0] {StActive, StIdleCount, StGated, StWake} state_e;

  localparam logic [CNT_W-1:0] IdleLast = CNT_W'(IDLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] WakeLast = CNT_W'(WAKE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CntOne   = CNT_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             clk_en_d, gated_d, wake_ack_d;
  logic             idle;

  assign idle = !i_busy && !i_wake_req && i_gate_en;

  // State and registered outputs; reset forces the clock on without waiting for an edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= StActive;
      cnt_q      <= '0;
      o_clk_en   <= 1'b1;
      o_gated    <= 1'b0;
      o_wake_ack <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      o_clk_en   <= clk_en_d;
      o_gated    <= gated_d;
      o_wake_ack <= wake_ack_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    wake_ack_d = 1'b0;
    unique case (state_q)
      StActive: begin
        cnt_d = '0;
        if (idle) begin
          if (IDLE_CYCLES == 1) begin
            state_d = StGated;
          end else begin
            state_d = StIdleCount;
            cnt_d   = CntOne;
          end
        end
      end
      StIdleCount: begin
        if (!idle) begin
          state_d = StActive;
          cnt_d   = '0;
        end else if (cnt_q >= IdleLast) begin
          state_d = StGated;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      StGated: begin
        if (!idle) begin
          state_d = StWake;
          cnt_d   = '0;
        end
      end
      StWake: begin
        if (cnt_q >= WakeLast) begin
          wake_ack_d = 1'b1;
          // An idle sample on the acknowledge edge already counts towards the next window,
          // but the domain is always handed back usable for at least one cycle.
          if (idle && (IDLE_CYCLES > 1)) begin
            state_d = StIdleCount;
            cnt_d   = CntOne;
          end else begin
            state_d = StActive;
            cnt_d   = '0;
          end
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      default: begin
        state_d = StActive;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they land in registers alongside it.
  always_comb begin
    clk_en_d = (state_d != StGated);
    gated_d  = (state_d == StGated) || (state_d == StWake);
  end

endmodule

// File: tb/tb_clk_gate_ctrl.sv
// Scoreboard bench for clk_gate_ctrl: two instances (16/2 and 1/1) share randomized stimulus
// and are compared cycle by cycle against an idle-run/settle-count reference model.
module tb_clk_gate_ctrl;

  logic       clk      = 1'b0;
  logic       rst_n    = 1'b1;
  logic       busy     = 1'b0;
  logic       wake_req = 1'b0;
  logic       gate_en  = 1'b1;
  logic [1:0] clk_en, gated, wake_ack;

  clk_gate_ctrl #(.IDLE_CYCLES(16), .WAKE_CYCLES(2)) dut_a (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_busy     (busy),
    .i_wake_req (wake_req),
    .i_gate_en  (gate_en),
    .o_clk_en   (clk_en[0]),
    .o_gated    (gated[0]),
    .o_wake_ack (wake_ack[0])
  );

  clk_gate_ctrl #(.IDLE_CYCLES(1), .WAKE_CYCLES(1)) dut_b (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_busy     (busy),
    .i_wake_req (wake_req),
    .i_gate_en  (gate_en),
    .o_clk_en   (clk_en[1]),
    .o_gated    (gated[1]),
    .o_wake_ack (wake_ack[1])
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] clk_en;
    logic [1:0] gated;
    logic [1:0] ack;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference model: mode 0 = usable, 1 = gated, 2 = settling after wake.
  int         icyc[2] = '{16, 1};
  int         wcyc[2] = '{2, 1};
  int         mode[2];
  int         run[2];
  int         wt[2];
  logic [1:0] m_ack;

  function automatic void model_reset();
    for (int i = 0; i < 2; i++) begin
      mode[i]  = 0;
      run[i]   = 0;
      wt[i]    = 0;
      m_ack[i] = 1'b0;
    end
  endfunction

  function automatic void model_step(input bit idle);
    for (int i = 0; i < 2; i++) begin
      m_ack[i] = 1'b0;
      case (mode[i])
        0: begin
          run[i] = idle ? run[i] + 1 : 0;
          if (run[i] >= icyc[i]) begin
            mode[i] = 1;
            run[i]  = 0;
          end
        end
        1: begin
          if (!idle) begin
            mode[i] = 2;
            wt[i]   = 0;
          end
        end
        default: begin
          wt[i] = wt[i] + 1;
          if (wt[i] >= wcyc[i]) begin
            mode[i]  = 0;
            m_ack[i] = 1'b1;
            run[i]   = (idle && icyc[i] > 1) ? 1 : 0;
          end
        end
      endcase
    end
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      e.clk_en[i] = (mode[i] != 1);
      e.gated[i]  = (mode[i] != 0);
      e.ack[i]    = m_ack[i];
    end
    return e;
  endfunction

  task automatic check(input string name, input logic [1:0] act, input logic [1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b (bit0=16/2, bit1=1/1) at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs on the falling edge and queue the expected post-edge outputs.
  task automatic cyc(input bit r, input bit b, input bit w, input bit g);
    logic prev_rst;
    @(negedge clk);
    prev_rst = rst_n;
    rst_n    = r;
    busy     = b;
    wake_req = w;
    gate_en  = g;
    if (!r) begin
      model_reset();
      if (prev_rst) begin
        #1;
        check("async_rst_clk_en", clk_en, 2'b11);
        check("async_rst_gated", gated, 2'b00);
        check("async_rst_ack", wake_ack, 2'b00);
      end
    end else begin
      model_step(!b && !w && g);
    end
    exp_q.push_back(model_out());
  endtask

  task automatic idle_n(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b0, 1'b1);
  endtask

  // Monitor: every rising edge consumes one queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("clk_en", clk_en, e.clk_en);
        check("gated", gated, e.gated);
        check("wake_ack", wake_ack, e.ack);
      end
    end
  end

  initial begin
    int k;
    int len;
    model_reset();
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    idle_n(20);
    cyc(1'b1, 1'b0, 1'b1, 1'b1);
    cyc(1'b1, 1'b1, 1'b0, 1'b1);
    idle_n(10);
    cyc(1'b1, 1'b1, 1'b0, 1'b1);
    idle_n(20);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 100; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0);
    // Reset while settling after a wake, then while counting idle.
    idle_n(20);
    cyc(1'b1, 1'b0, 1'b1, 1'b1);
    cyc(1'b1, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    idle_n(5);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    idle_n(20);
    for (int i = 0; i < 10; i++) begin
      cyc(1'b1, 1'b0, 1'b1, 1'b1);
      idle_n(1);
    end
    for (int s = 0; s < 300; s++) begin
      k   = int'($urandom_range(0, 19));
      len = int'($urandom_range(1, 24));
      if (k < 12) begin
        idle_n(len);
      end else if (k < 15) begin
        for (int i = 0; i < len % 4 + 1; i++) cyc(1'b1, 1'b1, $urandom_range(0, 1) == 1, 1'b1);
      end else if (k < 17) begin
        for (int i = 0; i < len % 3 + 1; i++) cyc(1'b1, 1'b0, 1'b1, $urandom_range(0, 1) == 1);
      end else if (k < 19) begin
        for (int i = 0; i < len % 5 + 1; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0);
      end else begin
        for (int i = 0; i < len % 2 + 1; i++)
          cyc(1'b0, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, 1'b1);
      end
    end
    idle_n(2);
    @(posedge clk);
    #2;
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/clk_gate_ctrl.md
# clk_gate_ctrl

Idle-detect controller that produces the clock-enable for the downstream latch-based clock gate. It runs on the free-running, ungated clock. It watches the gated domain's activity and external wake requests, and withdraws the enable after a programmable idle window. On wake it restores the enable and holds a settle window before acknowledging.

## Interface
Parameters:
- IDLE_CYCLES, 16: consecutive idle samples required before gating; legal range ≥1.
- WAKE_CYCLES, 2: settle cycles after re-enable before the acknowledge; legal range ≥1.
- CNT_W, $clog2(max(IDLE_CYCLES, WAKE_CYCLES)+1): internal counter width, derived.

Ports:
- i_clk, input, 1: free-running clock, never the gated clock.
- i_rst_n, input, 1: asynchronous active-low reset.
- i_busy, input, 1: gated domain has pending or ongoing work.
- i_wake_req, input, 1: external wake request, level.
- i_gate_en, input, 1: global permission to gate; 0 forces the clock on.
- o_clk_en, output, 1: registered enable to the clock gate.
- o_gated, output, 1: high in GATED and WAKE (domain not yet usable).
- o_wake_ack, output, 1: one-cycle pulse when the domain becomes usable after a wake.

## Operation
- Idle condition: idle = !i_busy & !i_wake_req & i_gate_en. Wake condition: wake = !idle.
- All outputs and state are registered.
- Reset values: state ACTIVE, counter 0, o_clk_en=1, o_gated=0, o_wake_ack=0.
- ACTIVE (o_clk_en=1, o_gated=0):
  - idle with IDLE_CYCLES==1 → GATED.
  - idle otherwise → IDLE_COUNT with counter=1.
  - wake → stay in ACTIVE.
- IDLE_COUNT (o_clk_en=1, o_gated=0):
  - wake → ACTIVE, counter=0.
  - idle with counter==IDLE_CYCLES-1 → GATED.
  - idle otherwise → counter+1.
- GATED (o_clk_en=0, o_gated=1):
  - wake → WAKE with counter=0 and o_clk_en=1 from that edge.
  - idle → stay in GATED.
- WAKE (o_clk_en=1, o_gated=1):
  - Inputs are ignored; the wake always completes.
  - Counter increments each cycle.
  - At counter==WAKE_CYCLES-1 → ACTIVE, o_gated=0, o_wake_ack=1 for exactly one cycle.
  - If idle is present on arrival in ACTIVE, the normal idle count starts that same edge.
- o_wake_ack is asserted only on the WAKE→ACTIVE transition and never after reset.
- Counter saturation: the counter never exceeds its terminal value and resets on every state change.

## Timing
- Gating latency: idle sampled on edges 1..N, with N=IDLE_CYCLES, all consecutive → o_clk_en low after edge N. Any non-idle sample restarts the count.
- Wake latency:
  - wake sampled at edge k in GATED → o_clk_en high after edge k.
  - o_gated low and o_wake_ack high after edge k+WAKE_CYCLES.
  - o_wake_ack low after edge k+WAKE_CYCLES+1.
- o_clk_en changes only on i_clk rising edges. The downstream gate latches it while the clock is low, so the gated clock loses or gains whole pulses only.
- i_gate_en falling while GATED is treated as a wake, with the same latency.
- Simultaneous idle and wake in the same cycle cannot occur; wake dominates by definition.
- Asynchronous reset mid-operation, in any state: o_clk_en=1 and o_gated=0 immediately on i_rst_n low, without waiting for a clock edge. o_wake_ack=0. No acknowledge is issued on reset release.

## Test plan
- Reset, then idle held with IDLE_CYCLES=16 → o_clk_en stays 1 through edge 15 and is 0 after edge 16; o_gated=1 from the same edge.
- Idle for 10 cycles, then i_busy pulses for 1 cycle, then idle again → no gating until 16 new consecutive idle samples.
- From GATED, i_wake_req pulses for 1 cycle at edge k with WAKE_CYCLES=2 → o_clk_en=1 after k; o_wake_ack is a single pulse after k+2; state is ACTIVE.
- From GATED, i_gate_en driven to 0 → wake sequence as above. With i_gate_en held 0 and i_busy=0 for 100 cycles, o_clk_en stays 1.
- i_rst_n asserted while in WAKE and while in IDLE_COUNT → outputs equal reset values asynchronously; no o_wake_ack after release.
- IDLE_CYCLES=1, WAKE_CYCLES=1: a single idle sample gates; a wake acknowledges one edge later. Also check back-to-back gate/wake cycles for correct pulse counts.
